// File: rtl/mod_counter_pkg.sv
// ============================================================================
// Module      : mod_counter_pkg
// Description : Shared direction encoding and elaboration helpers for mod_counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_counter_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic int clog2(input longint unsigned value);
        int result;
        result = 0;
        while ((longint'(1) << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit width_legal(input int unsigned width);
        return (width >= 1) && (width <= 32);
    endfunction

    function automatic bit modulo_legal(input int unsigned width, input longint unsigned modulo);
        return (modulo == 0) || ((modulo >= 2) && (modulo <= (64'd1 << width)));
    endfunction

    function automatic bit prescale_legal(input longint unsigned prescale);
        return (prescale >= 1) && (prescale <= 65536);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prescaler_tick.sv
// ============================================================================
// Module      : prescaler_tick
// Description : Enabled-cycle divider producing a combinational step strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prescaler_tick
    import mod_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic CLR,
    output logic STEP
);

    localparam int PRE_W = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    always_comb begin
        STEP  = EN && (pre_q == PRE_LAST);
        pre_d = pre_q;
        if (CLR) begin
            pre_d = '0;
        end else if (EN) begin
            pre_d = STEP ? '0 : pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
// Module      : mod_counter
// Description : Up/down modulo counter with prescaler, load, wrap/saturate and TC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 31,
    parameter longint unsigned MODULO   = 0,
    parameter int unsigned     PRESCALE = 1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             DIR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] COUNT,
    output logic             TC,
    output logic             TICK
);

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("mod_counter: WIDTH must be 1..32");
    end
    if (!modulo_legal(WIDTH, MODULO)) begin : g_bad_modulo
        $error("mod_counter: MODULO must be 0 or 2..2**WIDTH");
    end
    if (!prescale_legal(PRESCALE)) begin : g_bad_prescale
        $error("mod_counter: PRESCALE must be 1..65536");
    end

    // Full-range mode terminates at all-ones and wraps by natural overflow.
    localparam logic [WIDTH-1:0] TERM = (MODULO == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULO - 1);

    logic             step;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             tick_q, tick_d;

    prescaler_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .CLR  (LOAD),
        .STEP (step)
    );

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        tick_d  = 1'b0;
        if (LOAD) begin
            count_d = (LOAD_VAL > TERM) ? TERM : LOAD_VAL;
        end else if (step) begin
            tick_d = 1'b1;
            if (dir_e'(DIR) == DIR_UP) begin
                if (count_q == TERM) begin
                    tc_d = 1'b1;
                    if (!SATURATE) begin
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    tc_d = 1'b1;
                    if (!SATURATE) begin
                        count_d = TERM;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            tick_q  <= tick_d;
        end
    end

    assign COUNT = count_q;
    assign TC    = tc_q;
    assign TICK  = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ============================================================================
// Module      : tb_mod_counter
// Description : Scoreboard bench driving four mod_counter configurations in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_counter;

    logic        CLK = 1'b0;
    logic        RST, EN, DIR, LOAD;
    logic [30:0] lv;

    logic [3:0]  count_a, count_b, count_c;
    logic [30:0] count_d;
    logic        tc_a, tc_b, tc_c, tc_d;
    logic        tick_a, tick_b, tick_c, tick_d;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // a: mod-10 wrap, b: mod-10 prescale 3, c: mod-10 saturate, d: defaults
    mod_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(1), .SATURATE(1'b0)) u_a (
        .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .LOAD(LOAD), .LOAD_VAL(lv[3:0]),
        .COUNT(count_a), .TC(tc_a), .TICK(tick_a));
    mod_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(3), .SATURATE(1'b0)) u_b (
        .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .LOAD(LOAD), .LOAD_VAL(lv[3:0]),
        .COUNT(count_b), .TC(tc_b), .TICK(tick_b));
    mod_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(1), .SATURATE(1'b1)) u_c (
        .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .LOAD(LOAD), .LOAD_VAL(lv[3:0]),
        .COUNT(count_c), .TC(tc_c), .TICK(tick_c));
    mod_counter u_d (
        .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .LOAD(LOAD), .LOAD_VAL(lv),
        .COUNT(count_d), .TC(tc_d), .TICK(tick_d));

    typedef struct {
        int          id;
        logic [30:0] count;
        logic        tc;
        logic        tick;
    } exp_t;

    exp_t sb[$];

    localparam longint unsigned C_MOD  [4] = '{64'd10, 64'd10, 64'd10, 64'h8000_0000};
    localparam int              C_PS   [4] = '{1, 3, 1, 1};
    localparam bit              C_SAT  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    localparam longint unsigned C_MASK [4] = '{64'hF, 64'hF, 64'hF, 64'h7FFF_FFFF};

    longint unsigned m_count [4] = '{0, 0, 0, 0};
    int              m_pre   [4] = '{0, 0, 0, 0};
    bit              m_tc    [4] = '{0, 0, 0, 0};
    bit              m_tick  [4] = '{0, 0, 0, 0};

    function automatic logic [32:0] act(input int id);
        case (id)
            0:       return {tick_a, tc_a, 27'd0, count_a};
            1:       return {tick_b, tc_b, 27'd0, count_b};
            2:       return {tick_c, tc_c, 27'd0, count_c};
            default: return {tick_d, tc_d, count_d};
        endcase
    endfunction

    // Drive one edge of stimulus, advance the reference model, queue expectations.
    task automatic cycle(input bit rst, input bit ld, input bit en, input bit dir,
                         input logic [30:0] val);
        RST = rst; LOAD = ld; EN = en; DIR = dir; lv = val;
        for (int i = 0; i < 4; i++) begin
            longint unsigned term, v;
            bit st;
            term = C_MOD[i] - 1;
            v    = longint'(val) & C_MASK[i];
            if (rst) begin
                m_count[i] = 0; m_pre[i] = 0; m_tc[i] = 0; m_tick[i] = 0;
            end else if (ld) begin
                m_count[i] = (v > term) ? term : v;
                m_pre[i] = 0; m_tc[i] = 0; m_tick[i] = 0;
            end else begin
                st = en && (m_pre[i] == C_PS[i] - 1);
                if (en) m_pre[i] = st ? 0 : m_pre[i] + 1;
                m_tick[i] = st;
                m_tc[i]   = 0;
                if (st && !dir) begin
                    if (m_count[i] == term) begin
                        m_tc[i] = 1;
                        if (!C_SAT[i]) m_count[i] = 0;
                    end else m_count[i] = m_count[i] + 1;
                end else if (st && dir) begin
                    if (m_count[i] == 0) begin
                        m_tc[i] = 1;
                        if (!C_SAT[i]) m_count[i] = term;
                    end else m_count[i] = m_count[i] - 1;
                end
            end
            sb.push_back('{id: i, count: m_count[i][30:0], tc: m_tc[i], tick: m_tick[i]});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [32:0] got, want;
        for (int k = 0; k < 2; k++) begin
            cycle(1, 0, 0, 0, 31'd0);
            while (sb.size() > 0) begin
                e = sb.pop_front(); got = act(e.id); want = {e.tick, e.tc, e.count};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL reset dut%0d: got %h expected %h", e.id, got, want);
                end
            end
        end
        checks++;
        if ({count_a, tc_a, tick_a, count_d, tc_d, tick_d} !== 37'd0) begin
            errors++;
            $display("FAIL reset_zero: got a=%h/%b/%b d=%h/%b/%b expected all zero",
                     count_a, tc_a, tick_a, count_d, tc_d, tick_d);
        end
    endtask

    task automatic test_count_up();
        exp_t e;
        logic [32:0] got, want;
        cycle(1, 0, 0, 0, 31'd0);
        void'(sb.size());
        sb.delete();
        for (int i = 0; i < 12; i++) begin
            cycle(0, 0, 1, 0, 31'd0);
            while (sb.size() > 0) begin
                e = sb.pop_front(); got = act(e.id); want = {e.tick, e.tc, e.count};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL count_up dut%0d: got %h expected %h", e.id, got, want);
                end
            end
            checks++;
            if (count_a !== 4'((i + 1) % 10) || tc_a !== 1'(i == 9)) begin
                errors++;
                $display("FAIL count_up_seq step%0d: got count=%0d tc=%b expected count=%0d tc=%b",
                         i, count_a, tc_a, (i + 1) % 10, i == 9);
            end
        end
    endtask

    task automatic test_count_down();
        exp_t e;
        logic [32:0] got, want;
        bit en;
        cycle(1, 0, 0, 0, 31'd0);
        sb.delete();
        for (int i = 0; i < 10; i++) begin
            en = !(i >= 4 && i < 7);
            cycle(0, 0, en, 1, 31'd0);
            while (sb.size() > 0) begin
                e = sb.pop_front(); got = act(e.id); want = {e.tick, e.tc, e.count};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL count_down dut%0d cyc%0d: got %h expected %h", e.id, i, got, want);
                end
            end
            if (i == 0) begin
                checks++;
                if (count_a !== 4'd9 || tc_a !== 1'b1) begin
                    errors++;
                    $display("FAIL down_first: got count=%0d tc=%b expected count=9 tc=1", count_a, tc_a);
                end
            end
            if (i == 5) begin
                checks++;
                if (count_a !== 4'd6 || tc_a !== 1'b0 || tick_a !== 1'b0) begin
                    errors++;
                    $display("FAIL down_frozen: got count=%0d tc=%b tick=%b expected 6/0/0",
                             count_a, tc_a, tick_a);
                end
            end
        end
    endtask

    task automatic test_prescale();
        exp_t e;
        logic [32:0] got, want;
        cycle(1, 0, 0, 0, 31'd0);
        sb.delete();
        for (int i = 0; i < 9; i++) begin
            cycle(0, 0, 1, 0, 31'd0);
            while (sb.size() > 0) begin
                e = sb.pop_front(); got = act(e.id); want = {e.tick, e.tc, e.count};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL prescale dut%0d: got %h expected %h", e.id, got, want);
                end
            end
            checks++;
            if (tick_b !== 1'(i % 3 == 2) || count_b !== 4'((i + 1) / 3)) begin
                errors++;
                $display("FAIL prescale_seq cyc%0d: got count=%0d tick=%b expected count=%0d tick=%b",
                         i, count_b, tick_b, (i + 1) / 3, i % 3 == 2);
            end
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        logic [32:0] got, want;
        logic [3:0] exp_cnt [7] = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0};
        logic       exp_tc  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        cycle(1, 0, 0, 0, 31'd0);
        sb.delete();
        for (int i = 0; i < 7; i++) begin
            cycle(0, (i == 0 || i == 4), 1, (i >= 4), (i == 0) ? 31'd8 : 31'd0);
            while (sb.size() > 0) begin
                e = sb.pop_front(); got = act(e.id); want = {e.tick, e.tc, e.count};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL saturate dut%0d: got %h expected %h", e.id, got, want);
                end
            end
            checks++;
            if (count_c !== exp_cnt[i] || tc_c !== exp_tc[i]) begin
                errors++;
                $display("FAIL saturate_seq cyc%0d: got count=%0d tc=%b expected count=%0d tc=%b",
                         i, count_c, tc_c, exp_cnt[i], exp_tc[i]);
            end
        end
    endtask

    task automatic test_load();
        exp_t e;
        logic [32:0] got, want;
        cycle(1, 0, 0, 0, 31'd0);
        sb.delete();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0:       cycle(0, 1, 0, 0, 31'd13);
                3:       cycle(0, 1, 1, 0, 31'd5);
                default: cycle(0, 0, 1, 0, 31'd0);
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front(); got = act(e.id); want = {e.tick, e.tc, e.count};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL load dut%0d cyc%0d: got %h expected %h", e.id, i, got, want);
                end
            end
            if (i == 0) begin
                checks++;
                if (count_a !== 4'd9 || tc_a !== 1'b0) begin
                    errors++;
                    $display("FAIL load_clamp: got count=%0d tc=%b expected 9/0", count_a, tc_a);
                end
            end
            if (i >= 3) begin
                checks++;
                if (tick_b !== 1'(i == 6) || count_b !== ((i == 6) ? 4'd6 : 4'd5)) begin
                    errors++;
                    $display("FAIL load_restart cyc%0d: got count=%0d tick=%b expected count=%0d tick=%b",
                             i, count_b, tick_b, (i == 6) ? 6 : 5, i == 6);
                end
            end
        end
    endtask

    task automatic test_full_range();
        exp_t e;
        logic [32:0] got, want;
        cycle(1, 0, 0, 0, 31'd0);
        sb.delete();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       cycle(0, 1, 0, 0, 31'h7FFF_FFFE);
                5:       cycle(1, 1, 1, 1, 31'h1234);
                default: cycle(0, 0, 1, 0, 31'd0);
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front(); got = act(e.id); want = {e.tick, e.tc, e.count};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL full_range dut%0d cyc%0d: got %h expected %h", e.id, i, got, want);
                end
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (count_d !== ((i == 1) ? 31'h7FFF_FFFF : 31'd0) || tc_d !== 1'(i == 2)) begin
                    errors++;
                    $display("FAIL full_wrap cyc%0d: got count=%h tc=%b", i, count_d, tc_d);
                end
            end
            if (i == 5) begin
                checks++;
                if (count_d !== 31'd0 || tc_d !== 1'b0 || tick_d !== 1'b0 || count_b !== 4'd0) begin
                    errors++;
                    $display("FAIL rst_over_load: got d=%h/%b/%b b=%0d expected zeros",
                             count_d, tc_d, tick_d, count_b);
                end
            end
        end
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; DIR = 1'b0; LOAD = 1'b0; lv = '0;
        test_reset();
        test_count_up();
        test_count_down();
        test_prescale();
        test_saturate();
        test_load();
        test_full_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
